vend_txn_ctrl: RTL and testbench
================================

Name: vend_txn_ctrl

Overview:
Transaction controller for the drink vending machine. It serialises coin-insert, product-select and cancel requests into one accepted event per cycle and owns the credit register. It issues one-cycle vend strobes and sequences change return through a coin hopper, one 5-unit coin at a time, using a ready/ack handshake. It sits between the debounced front-panel pulse generators and the dispenser/hopper drivers; its credit output feeds the display block.

Parameters:
MAX_CREDIT, 50, highest credit accepted; a coin that would exceed it is rejected
PRICE_TEA, 10, tea price
PRICE_COKE, 15, coke price
PRICE_SPRITE, 20, sprite price
ACK_TIMEOUT, 255, cycles to wait for hopper_ack before faulting (8-bit counter)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
cancel  in  1  one-cycle pulse: refund all credit
money_5 / money_10 / money_50  in  1 each  one-cycle coin-insert pulses
tea / coke / sprite  in  1 each  one-cycle product-select pulses
hopper_ready  in  1  hopper can accept a coin request
hopper_ack  in  1  hopper has ejected the requested 5-unit coin
coin5_out  out  1  change-coin request, held until ack
coin_reject  out  1  one-cycle pulse: inserted coin returned unaccepted
vend_tea / vend_coke / vend_sprite  out  1 each  one-cycle dispense strobes
drop_tea / drop_coke / drop_sprite  out  1 each  active-low "affordable" lamps
credit  out  8  current credit, unsigned
busy  out  1  high in any state other than IDLE
fault  out  1  sticky hopper-timeout flag
state  out  2  IDLE=0, CHANGE=1, WAIT_ACK=2, FAULT=3

Behaviour:
- Reset (async, rst_n=0): state=IDLE; credit=0; coin5_out, coin_reject, vend_*, fault, busy = 0; drop_* = 1; timeout counter = 0. Reset mid-operation abandons the transaction. Remaining credit is lost and is not refunded.
- All state, credit and strobe outputs are registered. drop_* and busy decode from registered state and credit only.
- IDLE arbitration, fixed priority: cancel > money_50 > money_10 > money_5 > tea > coke > sprite.
  - Exactly one request is serviced per cycle. Lower-priority pulses in the same cycle are dropped, not queued.
- Coin in IDLE:
  - If credit+value <= MAX_CREDIT, credit += value on the next edge.
  - Otherwise credit is unchanged and coin_reject pulses for one cycle.
  - Addition uses a 9-bit intermediate; no wrap.
- Product in IDLE:
  - If credit >= price: credit -= price, the matching vend_* pulses high for exactly one cycle (the cycle after the request), and state goes to CHANGE.
  - If credit < price: the request is ignored and there is no output change.
- Cancel in IDLE: credit > 0 goes to CHANGE; credit == 0 is ignored.
- CHANGE:
  - credit == 0: go to IDLE.
  - else if hopper_ready: assert coin5_out, clear the timeout counter, go to WAIT_ACK.
  - else: remain in CHANGE.
- WAIT_ACK:
  - coin5_out is held high and the counter increments each cycle.
  - On hopper_ack: credit -= 5, coin5_out = 0, go to CHANGE. This gives at least 2 cycles per coin.
  - If the counter reaches ACK_TIMEOUT with no ack: go to FAULT.
- FAULT: coin5_out = 0, fault = 1, busy = 1. credit is frozen. All inputs are ignored. Only reset exits.
- Credit is never decremented below 0. hopper_ack outside WAIT_ACK is ignored.
- Credit is always a multiple of 5 because coins and prices are multiples of 5. Change loop count = credit/5.
- All panel inputs are ignored while busy=1. Coins arriving while busy are not rejected, so the front panel must gate them.
- drop_x = 0 iff state==IDLE and credit >= PRICE_x. Otherwise drop_x = 1.

Test Plan:
- Reset, then money_10, money_10, money_5 on separate cycles -> credit 10, 20, 25. drop_tea = drop_coke = drop_sprite = 0 after the third coin.
- credit=25, coke pulse -> vend_coke high for 1 cycle, credit=10, state CHANGE. With hopper_ready=1 and ack 3 cycles after each coin5_out: 2 coin5_out handshakes, credit 0, state IDLE, busy=0.
- credit=45, money_10 -> coin_reject pulse, credit stays 45. money_5 -> credit 50. money_50 -> reject.
- Same cycle cancel+money_50+tea with credit=15 -> only cancel serviced, 3 change coins, no vend, credit ends 0.
- credit=20, sprite -> vend_sprite, credit 0, CHANGE->IDLE in one cycle, no coin5_out. tea with credit=5 -> ignored.
- credit=10, cancel, hopper_ready=1, never ack -> after ACK_TIMEOUT cycles state=3, fault=1, credit=10. Assert rst_n=0 -> all outputs at reset values.

Source files
------------

// File: rtl/vend_txn_ctrl.sv
// Vending-machine transaction controller: arbitrates panel requests, owns credit,
// strobes dispensers and pays change one 5-unit coin at a time through the hopper.
module vend_txn_ctrl #(
   parameter int unsigned MAX_CREDIT   = 50,
   parameter int unsigned PRICE_TEA    = 10,
   parameter int unsigned PRICE_COKE   = 15,
   parameter int unsigned PRICE_SPRITE = 20,
   parameter int unsigned ACK_TIMEOUT  = 255
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cancel,
   input  logic       money_5,
   input  logic       money_10,
   input  logic       money_50,
   input  logic       tea,
   input  logic       coke,
   input  logic       sprite,
   input  logic       hopper_ready,
   input  logic       hopper_ack,
   output logic       coin5_out,
   output logic       coin_reject,
   output logic       vend_tea,
   output logic       vend_coke,
   output logic       vend_sprite,
   output logic       drop_tea,
   output logic       drop_coke,
   output logic       drop_sprite,
   output logic [7:0] credit,
   output logic       busy,
   output logic       fault,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StChange  = 2'd1,
      StWaitAck = 2'd2,
      StFault   = 2'd3
   } state_e;

   localparam logic [8:0] MaxSum      = 9'(MAX_CREDIT);
   localparam logic [7:0] PriceTea    = 8'(PRICE_TEA);
   localparam logic [7:0] PriceCoke   = 8'(PRICE_COKE);
   localparam logic [7:0] PriceSprite = 8'(PRICE_SPRITE);
   localparam logic [7:0] CoinValue   = 8'd5;
   // Last counter value before giving up, so WAIT_ACK lasts ACK_TIMEOUT cycles.
   localparam logic [7:0] TimeoutLast = 8'(ACK_TIMEOUT - 1);

   state_e     state_q, state_d;
   logic [7:0] credit_q, credit_d;
   logic [7:0] cnt_q, cnt_d;
   logic       coin5_q, coin5_d;
   logic       reject_q, reject_d;
   logic       fault_q, fault_d;
   logic [2:0] vend_q, vend_d;  // {tea, coke, sprite}

   logic       coin_req;
   logic [8:0] coin_val;
   logic [8:0] coin_sum;
   logic       prod_req;
   logic [7:0] sel_price;
   logic [2:0] sel_vend;

   always_comb begin
      coin_req = money_50 | money_10 | money_5;
      coin_val = 9'd0;
      if (money_50) begin
         coin_val = 9'd50;
      end else if (money_10) begin
         coin_val = 9'd10;
      end else if (money_5) begin
         coin_val = 9'd5;
      end
      coin_sum = {1'b0, credit_q} + coin_val;

      prod_req  = tea | coke | sprite;
      sel_price = 8'd0;
      sel_vend  = 3'b000;
      if (tea) begin
         sel_price = PriceTea;
         sel_vend  = 3'b100;
      end else if (coke) begin
         sel_price = PriceCoke;
         sel_vend  = 3'b010;
      end else if (sprite) begin
         sel_price = PriceSprite;
         sel_vend  = 3'b001;
      end
   end

   always_comb begin
      state_d  = state_q;
      credit_d = credit_q;
      cnt_d    = cnt_q;
      coin5_d  = coin5_q;
      fault_d  = fault_q;
      reject_d = 1'b0;
      vend_d   = 3'b000;

      unique case (state_q)
         StIdle: begin
            if (cancel) begin
               if (credit_q != 8'd0) begin
                  state_d = StChange;
               end
            end else if (coin_req) begin
               if (coin_sum <= MaxSum) begin
                  credit_d = coin_sum[7:0];
               end else begin
                  reject_d = 1'b1;
               end
            end else if (prod_req) begin
               if (credit_q >= sel_price) begin
                  credit_d = credit_q - sel_price;
                  vend_d   = sel_vend;
                  state_d  = StChange;
               end
            end
         end
         StChange: begin
            if (credit_q == 8'd0) begin
               state_d = StIdle;
            end else if (hopper_ready) begin
               coin5_d = 1'b1;
               cnt_d   = 8'd0;
               state_d = StWaitAck;
            end
         end
         StWaitAck: begin
            coin5_d = 1'b1;
            if (hopper_ack) begin
               credit_d = (credit_q >= CoinValue) ? credit_q - CoinValue : 8'd0;
               coin5_d  = 1'b0;
               state_d  = StChange;
            end else if (cnt_q == TimeoutLast) begin
               coin5_d = 1'b0;
               fault_d = 1'b1;
               state_d = StFault;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         StFault: begin
            coin5_d = 1'b0;
            fault_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         credit_q <= 8'd0;
         cnt_q    <= 8'd0;
         coin5_q  <= 1'b0;
         reject_q <= 1'b0;
         fault_q  <= 1'b0;
         vend_q   <= 3'b000;
      end else begin
         state_q  <= state_d;
         credit_q <= credit_d;
         cnt_q    <= cnt_d;
         coin5_q  <= coin5_d;
         reject_q <= reject_d;
         fault_q  <= fault_d;
         vend_q   <= vend_d;
      end
   end

   assign coin5_out   = coin5_q;
   assign coin_reject = reject_q;
   assign vend_tea    = vend_q[2];
   assign vend_coke   = vend_q[1];
   assign vend_sprite = vend_q[0];
   assign credit      = credit_q;
   assign fault       = fault_q;
   assign state       = state_q;
   assign busy        = (state_q != StIdle);
   assign drop_tea    = ~((state_q == StIdle) && (credit_q >= PriceTea));
   assign drop_coke   = ~((state_q == StIdle) && (credit_q >= PriceCoke));
   assign drop_sprite = ~((state_q == StIdle) && (credit_q >= PriceSprite));

endmodule

// File: tb/tb_vend_txn_ctrl.sv
// Directed bench for vend_txn_ctrl: a credit/state model pushes expected results
// to a queue as each request is driven; they are popped and checked a cycle later.
module tb_vend_txn_ctrl;

   localparam int MAX_CREDIT   = 50;
   localparam int PRICE_TEA    = 10;
   localparam int PRICE_COKE   = 15;
   localparam int PRICE_SPRITE = 20;
   localparam int ACK_TIMEOUT  = 255;

   // {cancel, money_50, money_10, money_5, tea, coke, sprite}
   localparam logic [6:0] R_CANCEL = 7'b1000000;
   localparam logic [6:0] R_M50    = 7'b0100000;
   localparam logic [6:0] R_M10    = 7'b0010000;
   localparam logic [6:0] R_M5     = 7'b0001000;
   localparam logic [6:0] R_TEA    = 7'b0000100;
   localparam logic [6:0] R_COKE   = 7'b0000010;
   localparam logic [6:0] R_SPRITE = 7'b0000001;

   logic       clk, rst_n;
   logic       cancel, money_5, money_10, money_50, tea, coke, sprite;
   logic       hopper_ready, hopper_ack;
   logic       coin5_out, coin_reject, vend_tea, vend_coke, vend_sprite;
   logic       drop_tea, drop_coke, drop_sprite, busy, fault;
   logic [7:0] credit;
   logic [1:0] state;

   typedef struct {
      string      tag;
      logic [7:0] credit;
      logic [1:0] state;
      logic       reject;
      logic [2:0] vend;
      logic       coin5;
   } exp_t;

   exp_t       sb[$];
   int         checks = 0;
   int         errors = 0;
   logic [7:0] m_credit = 8'd0;
   logic [1:0] m_state  = 2'd0;

   vend_txn_ctrl #(
      .MAX_CREDIT  (MAX_CREDIT),
      .PRICE_TEA   (PRICE_TEA),
      .PRICE_COKE  (PRICE_COKE),
      .PRICE_SPRITE(PRICE_SPRITE),
      .ACK_TIMEOUT (ACK_TIMEOUT)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cancel      (cancel),
      .money_5     (money_5),
      .money_10    (money_10),
      .money_50    (money_50),
      .tea         (tea),
      .coke        (coke),
      .sprite      (sprite),
      .hopper_ready(hopper_ready),
      .hopper_ack  (hopper_ack),
      .coin5_out   (coin5_out),
      .coin_reject (coin_reject),
      .vend_tea    (vend_tea),
      .vend_coke   (vend_coke),
      .vend_sprite (vend_sprite),
      .drop_tea    (drop_tea),
      .drop_coke   (drop_coke),
      .drop_sprite (drop_sprite),
      .credit      (credit),
      .busy        (busy),
      .fault       (fault),
      .state       (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_sb();
      exp_t e;
      e = sb.pop_front();
      chk({e.tag, "_credit"}, 32'(credit), 32'(e.credit));
      chk({e.tag, "_state"}, 32'(state), 32'(e.state));
      chk({e.tag, "_reject"}, 32'(coin_reject), 32'(e.reject));
      chk({e.tag, "_vend"}, 32'({vend_tea, vend_coke, vend_sprite}), 32'(e.vend));
      chk({e.tag, "_coin5"}, 32'(coin5_out), 32'(e.coin5));
   endtask

   // Model one panel request and drive it for a single cycle.
   task automatic apply(input string tag, input logic [6:0] req);
      exp_t       e;
      int         v;
      logic [7:0] price;
      logic [2:0] vb;
      e.tag    = tag;
      e.credit = m_credit;
      e.state  = m_state;
      e.reject = 1'b0;
      e.vend   = 3'b000;
      e.coin5  = 1'b0;
      price    = 8'd0;
      vb       = 3'b000;
      if (m_state == 2'd0) begin
         if (req[6]) begin
            if (m_credit != 8'd0) e.state = 2'd1;
         end else if (req[5:3] != 3'b000) begin
            v = req[5] ? 50 : (req[4] ? 10 : 5);
            if (int'(m_credit) + v <= MAX_CREDIT) e.credit = 8'(int'(m_credit) + v);
            else e.reject = 1'b1;
         end else if (req[2:0] != 3'b000) begin
            if (req[2]) begin
               price = 8'(PRICE_TEA);
               vb    = 3'b100;
            end else if (req[1]) begin
               price = 8'(PRICE_COKE);
               vb    = 3'b010;
            end else begin
               price = 8'(PRICE_SPRITE);
               vb    = 3'b001;
            end
            if (m_credit >= price) begin
               e.credit = m_credit - price;
               e.vend   = vb;
               e.state  = 2'd1;
            end
         end
      end
      sb.push_back(e);
      {cancel, money_50, money_10, money_5, tea, coke, sprite} = req;
      @(negedge clk);
      {cancel, money_50, money_10, money_5, tea, coke, sprite} = 7'b0;
      m_credit = e.credit;
      m_state  = e.state;
      check_sb();
   endtask

   // Serve the hopper until the controller returns to IDLE; ack ack_delay cycles after each request.
   task automatic run_change(input string tag, input int ack_delay);
      exp_t e;
      int   coins     = 0;
      int   guard     = 0;
      int   exp_coins = int'(m_credit) / 5;
      bit   first     = 1'b1;
      while (state != 2'd0 && guard < 400) begin
         @(negedge clk);
         guard++;
         if (first) begin
            chk({tag, "_vend_one_cycle"}, 32'({vend_tea, vend_coke, vend_sprite}), 32'd0);
            first = 1'b0;
         end
         if (coin5_out) begin
            chk({tag, "_wait_state"}, 32'(state), 32'd2);
            repeat (ack_delay - 1) @(negedge clk);
            chk({tag, "_coin5_held"}, 32'(coin5_out), 32'd1);
            chk({tag, "_credit_before_ack"}, 32'(credit), 32'(m_credit));
            e.tag    = {tag, "_ack"};
            e.credit = m_credit - 8'd5;
            e.state  = 2'd1;
            e.reject = 1'b0;
            e.vend   = 3'b000;
            e.coin5  = 1'b0;
            sb.push_back(e);
            hopper_ack = 1'b1;
            @(negedge clk);
            hopper_ack = 1'b0;
            m_credit   = e.credit;
            check_sb();
            coins++;
         end
      end
      m_state = 2'd0;
      chk({tag, "_in_budget"}, 32'(guard < 400), 32'd1);
      chk({tag, "_coins"}, 32'(coins), 32'(exp_coins));
      chk({tag, "_end_state"}, 32'(state), 32'd0);
      chk({tag, "_end_busy"}, 32'(busy), 32'd0);
      chk({tag, "_end_credit"}, 32'(credit), 32'd0);
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_state"}, 32'(state), 32'd0);
      chk({tag, "_credit"}, 32'(credit), 32'd0);
      chk({tag, "_coin5"}, 32'(coin5_out), 32'd0);
      chk({tag, "_reject"}, 32'(coin_reject), 32'd0);
      chk({tag, "_vend"}, 32'({vend_tea, vend_coke, vend_sprite}), 32'd0);
      chk({tag, "_fault"}, 32'(fault), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_drop"}, 32'({drop_tea, drop_coke, drop_sprite}), 32'b111);
   endtask

   initial begin
      int n;
      rst_n        = 1'b0;
      hopper_ready = 1'b1;
      hopper_ack   = 1'b0;
      {cancel, money_50, money_10, money_5, tea, coke, sprite} = 7'b0;
      repeat (2) @(negedge clk);
      check_reset("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Coin accumulation and lamps
      apply("m10_a", R_M10);
      chk("drop_at10", 32'({drop_tea, drop_coke, drop_sprite}), 32'b011);
      apply("m10_b", R_M10);
      apply("m5_a", R_M5);
      chk("drop_at25", 32'({drop_tea, drop_coke, drop_sprite}), 32'b000);

      // Coke purchase with two change coins
      apply("coke", R_COKE);
      chk("coke_busy", 32'(busy), 32'd1);
      chk("coke_drop_busy", 32'({drop_tea, drop_coke, drop_sprite}), 32'b111);
      run_change("coke_chg", 3);

      // Credit ceiling
      apply("to45_1", R_M10);
      apply("to45_2", R_M10);
      apply("to45_3", R_M10);
      apply("to45_4", R_M10);
      apply("to45_5", R_M5);
      apply("over_m10", R_M10);
      apply("to50", R_M5);
      apply("over_m50", R_M50);
      apply("cancel50", R_CANCEL);
      run_change("cancel50_chg", 2);

      // Simultaneous requests: cancel wins
      apply("to15_1", R_M10);
      apply("to15_2", R_M5);
      apply("prio", R_CANCEL | R_M50 | R_TEA);
      run_change("prio_chg", 3);

      // Exact-price purchase, then unaffordable request
      apply("to20_1", R_M10);
      apply("to20_2", R_M10);
      apply("sprite", R_SPRITE);
      run_change("sprite_chg", 3);
      apply("to5", R_M5);
      apply("tea_poor", R_TEA);
      apply("to10", R_M5);

      // Hopper never acknowledges
      apply("cancel_to", R_CANCEL);
      @(negedge clk);
      chk("to_coin5_up", 32'(coin5_out), 32'd1);
      n = 0;
      while (state != 2'd3 && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("to_cycles", 32'(n), 32'(ACK_TIMEOUT));
      chk("to_fault", 32'(fault), 32'd1);
      chk("to_busy", 32'(busy), 32'd1);
      chk("to_drop", 32'({drop_tea, drop_coke, drop_sprite}), 32'b111);
      m_state = 2'd3;
      apply("fault_coin", R_M10);
      apply("fault_cancel", R_CANCEL);

      // Asynchronous reset mid-fault
      #2;
      rst_n = 1'b0;
      #1;
      check_reset("reset2");
      @(negedge clk);
      rst_n = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
